fetch_coalescer: RTL and testbench
==================================

Name: fetch_coalescer

Overview:
Arbitrates the per-core instruction fetchers (NUM_CORES consumers) onto one program-memory read channel. It sits between the core fetchers and the program memory controller. When several cores request the same PC, a single memory read serves all of them in the same cycle. A one-entry line buffer holds the last fetched word, so repeat fetches of the same address complete without a memory access.

Parameters:
NUM_CONSUMERS, 2, number of fetchers (cores); must be >= 1
ADDR_BITS, 8, program memory address width
DATA_BITS, 16, instruction word width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  one-cycle pulse; invalidates the line buffer (asserted at kernel start)
consumer_read_valid  in  NUM_CONSUMERS  per-fetcher request; held high until its ready pulse
consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS (unpacked)  per-fetcher PC
consumer_read_ready  out  NUM_CONSUMERS  one-cycle response pulse per fetcher
consumer_read_data  out  DATA_BITS x NUM_CONSUMERS (unpacked)  response word; holds until the next response to that fetcher
mem_read_valid  out  1  memory request; held until mem_read_ready
mem_read_address  out  ADDR_BITS  memory address; stable while mem_read_valid is high
mem_read_ready  in  1  memory response strobe
mem_read_data  in  DATA_BITS  memory word; valid when mem_read_ready is high
hit_count  out  16  saturating count of buffer-served transactions
miss_count  out  16  saturating count of memory transactions

Behaviour:
- Reset (synchronous, active-high) sets the following to 0: state=IDLE, mem_read_valid, mem_read_address, all consumer_read_ready, all consumer_read_data, buf_valid, buf_addr, buf_data, rr_ptr, hit_count, miss_count.
- Reset asserted mid-transaction drops mem_read_valid at the next edge. Any in-flight memory response is ignored.
- State IDLE:
  - If buf_valid and any valid consumer address equals buf_addr: latch serve_mask = valid & (addr==buf_addr), resp_data=buf_data, go to RESPOND, increment hit_count.
  - Otherwise, if any consumer is valid: grant = first valid index at or after rr_ptr (wrapping modulo NUM_CONSUMERS). Latch req_addr = address[grant], drive mem_read_address, go to ISSUE.
  - A hit takes priority over a miss in the same cycle.
- State ISSUE:
  - mem_read_valid=1.
  - On mem_read_ready: resp_data=mem_read_data; buf_addr=req_addr; buf_data=mem_read_data; buf_valid=1 unless flush is high in the same cycle.
  - In the same cycle, latch serve_mask = valid & (addr==req_addr); this includes fetchers that raised valid during ISSUE.
  - Then mem_read_valid=0, increment miss_count, go to RESPOND.
- State RESPOND:
  - For one cycle, consumer_read_ready[i]=1 and consumer_read_data[i]=resp_data for every i in serve_mask.
  - rr_ptr = (highest-priority served index, counted from rr_ptr) + 1, wrapped.
  - Go to RELEASE.
- State RELEASE: wait until every served consumer has deasserted valid, then go to IDLE. Unserved requesters keep waiting; no request is dropped.
- Latency:
  - Hit: request sampled in IDLE at cycle t, ready pulse at t+1.
  - Miss: mem_read_valid high from t+1; if mem_read_ready arrives at cycle k, ready pulse at k+1.
- flush outside ISSUE: buf_valid=0 at the next edge. If flush and a hit decision coincide in IDLE, flush wins and the request is treated as a miss.
- Counters saturate at 0xFFFF; no wrap.
- Address 0 and address all-ones are ordinary addresses; buffer matching is an exact ADDR_BITS compare.
- NUM_CONSUMERS=1: rr_ptr is fixed at 0 and behaviour is otherwise identical.
- Fairness: a continuously requesting consumer is granted within NUM_CONSUMERS memory transactions.

Decomposition:
- Package fetch_pkg holds the state enum (IDLE, ISSUE, RESPOND, RELEASE) and the counter-width constant.
- One sub-module, rr_pick: combinational round-robin picker. Inputs: request mask and pointer. Outputs: one-hot grant, grant index, any_valid.
- Address compare and mask generation stay in the top-level module.

Test Plan:
1. Single miss: consumer0 requests 0x05; memory returns 0xABCD three cycles after mem_read_valid -> one memory transaction at address 0x05, consumer0 ready pulse with 0xABCD, miss_count=1, hit_count=0.
2. Coalesce: consumers 0 and 1 request 0x10 in the same cycle; memory returns 0x1234 -> exactly one mem_read_valid transaction, both ready pulses in the same cycle carrying 0x1234, miss_count=1.
3. Buffer hit: after test 2, consumer1 requests 0x10 -> mem_read_valid stays 0, ready pulse one cycle after the request with 0x1234, hit_count=1.
4. Round-robin: consumer0 continuously requests 0x20 and consumer1 continuously requests 0x21 (each re-requests after release), memory ready after 1 cycle, flush pulsed between transactions -> grant order 0,1,0,1 with no starvation.
5. Flush during ISSUE: flush coincides with mem_read_ready for 0x30 -> the response is still delivered; a following request for 0x30 misses (miss_count +1).
6. Reset mid-ISSUE -> mem_read_valid=0 at the next edge, counters=0, and a new request after reset is handled normally.

Source files
------------

// File: rtl/fetch_coalescer_pkg.sv
// Shared types and helpers for the instruction-fetch coalescer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESPOND,
    RELEASE
  } state_e;

  localparam int CNT_BITS = 16;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == '1) ? v : v + CNT_BITS'(1);
  endfunction

endpackage

// File: rtl/fetch_coalescer_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_valid
);

  int unsigned idx;
  logic [PW-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr) + off) % N;
      sel = PW'(idx);
      if (!any_valid && req[sel]) begin
        any_valid  = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/fetch_coalescer.sv
// Merges per-core instruction fetches onto one program-memory read port,
// coalescing same-PC requests and serving repeats from a one-entry line buffer.
module fetch_coalescer
  import fetch_pkg::*;
#(
  parameter int NUM_CONSUMERS = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
  output logic                     mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
);

  localparam int PW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  state_e                   state_q, state_d;
  logic                     mem_valid_q, mem_valid_d;
  logic [ADDR_BITS-1:0]     req_addr_q, req_addr_d;
  logic [NUM_CONSUMERS-1:0] serve_mask_q, serve_mask_d;
  logic [NUM_CONSUMERS-1:0] ready_q, ready_d;
  logic [DATA_BITS-1:0]     rdata_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     rdata_d [NUM_CONSUMERS];
  logic                     buf_valid_q, buf_valid_d;
  logic [ADDR_BITS-1:0]     buf_addr_q, buf_addr_d;
  logic [DATA_BITS-1:0]     buf_data_q, buf_data_d;
  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [CNT_BITS-1:0]      hit_q, hit_d, miss_q, miss_d;

  logic [NUM_CONSUMERS-1:0] hit_mask, fill_mask, pick_req, grant;
  logic [PW-1:0]            grant_idx;
  logic                     any_valid, buf_hit;
  logic [ADDR_BITS-1:0]     grant_addr;

  always_comb begin
    hit_mask   = '0;
    fill_mask  = '0;
    grant_addr = '0;
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      hit_mask[i]  = consumer_read_valid[i] && (consumer_read_address[i] == buf_addr_q);
      fill_mask[i] = consumer_read_valid[i] && (consumer_read_address[i] == req_addr_q);
      if (grant[i]) grant_addr = consumer_read_address[i];
    end
  end

  assign buf_hit = buf_valid_q && !flush && (hit_mask != '0);

  // One picker serves both uses: granting a miss in IDLE and, in RESPOND,
  // finding the first served index so rr_ptr can advance past it.
  assign pick_req = (state_q == RESPOND) ? serve_mask_q : consumer_read_valid;

  rr_pick #(.N(NUM_CONSUMERS), .PW(PW)) u_pick (
    .req       (pick_req),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (buf_hit) state_d = RESPOND;
               else if (any_valid) state_d = ISSUE;
      ISSUE:   if (mem_read_ready) state_d = RESPOND;
      RESPOND: state_d = RELEASE;
      RELEASE: if ((consumer_read_valid & serve_mask_q) == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_valid_d  = mem_valid_q;
    req_addr_d   = req_addr_q;
    serve_mask_d = serve_mask_q;
    ready_d      = '0;
    rdata_d      = rdata_q;
    buf_valid_d  = buf_valid_q && !flush;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    rr_ptr_d     = rr_ptr_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    unique case (state_q)
      IDLE: begin
        if (buf_hit) begin
          serve_mask_d = hit_mask;
          ready_d      = hit_mask;
          for (int unsigned i = 0; i < NUM_CONSUMERS; i++)
            if (hit_mask[i]) rdata_d[i] = buf_data_q;
          hit_d = sat_inc(hit_q);
        end else if (any_valid) begin
          req_addr_d  = grant_addr;
          mem_valid_d = 1'b1;
        end
      end
      ISSUE: begin
        if (mem_read_ready) begin
          serve_mask_d = fill_mask;
          ready_d      = fill_mask;
          for (int unsigned i = 0; i < NUM_CONSUMERS; i++)
            if (fill_mask[i]) rdata_d[i] = mem_read_data;
          buf_valid_d = !flush;
          buf_addr_d  = req_addr_q;
          buf_data_d  = mem_read_data;
          mem_valid_d = 1'b0;
          miss_d      = sat_inc(miss_q);
        end
      end
      RESPOND: begin
        if (any_valid)
          rr_ptr_d = (grant_idx == PW'(NUM_CONSUMERS - 1)) ? '0 : grant_idx + PW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      serve_mask_q <= '0;
      ready_q      <= '0;
      for (int unsigned i = 0; i < NUM_CONSUMERS; i++) rdata_q[i] <= '0;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      rr_ptr_q     <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      req_addr_q   <= req_addr_d;
      serve_mask_q <= serve_mask_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      rr_ptr_q     <= rr_ptr_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  assign consumer_read_ready = ready_q;
  assign consumer_read_data  = rdata_q;
  assign mem_read_valid      = mem_valid_q;
  assign mem_read_address    = req_addr_q;
  assign hit_count           = hit_q;
  assign miss_count          = miss_q;

endmodule

// File: tb/tb_fetch_coalescer.sv
// Bench for fetch_coalescer: directed scenarios plus a randomized run checked
// against a memory table and transaction-level accounting.
module tb_fetch_coalescer;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [N-1:0]  cvalid = '0;
  logic [AW-1:0] caddr [N];
  logic [N-1:0]  cready;
  logic [DW-1:0] cdata [N];
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [DW-1:0] mem_read_data;
  logic [15:0]   hit_count, miss_count;

  logic          mem_auto = 1'b0, mem_rand = 1'b0;
  logic          auto_ready = 1'b0, man_ready = 1'b0;
  logic [DW-1:0] auto_data = '0, man_data = '0;
  logic [DW-1:0] mem_tbl [256];
  int            mem_lat = 0;
  int            wait_cnt = 0;
  int            tests = 0, fails = 0;
  int            exp_hit = 0, exp_miss = 0;

  assign mem_read_ready = mem_auto ? auto_ready : man_ready;
  assign mem_read_data  = mem_auto ? auto_data : man_data;

  always #5 clk = ~clk;

  fetch_coalescer #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .flush                 (flush),
    .consumer_read_valid   (cvalid),
    .consumer_read_address (caddr),
    .consumer_read_ready   (cready),
    .consumer_read_data    (cdata),
    .mem_read_valid        (mem_read_valid),
    .mem_read_address      (mem_read_address),
    .mem_read_ready        (mem_read_ready),
    .mem_read_data         (mem_read_data),
    .hit_count             (hit_count),
    .miss_count            (miss_count)
  );

  // Memory model: answers from mem_tbl after mem_lat idle cycles.
  always @(negedge clk) begin
    if (auto_ready) auto_ready = 1'b0;
    else if (mem_auto && mem_read_valid && !reset) begin
      if (wait_cnt >= mem_lat) begin
        auto_ready = 1'b1;
        auto_data  = mem_tbl[mem_read_address];
        wait_cnt   = 0;
        if (mem_rand) mem_lat = $urandom_range(0, 3);
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; cvalid = '0; flush = 1'b0;
    caddr[0] = 8'($urandom); caddr[1] = 8'($urandom);
    step(3);
    reset = 1'b0;
    tests++; if (mem_read_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_valid got %b exp 0", mem_read_valid); end
    tests++; if (mem_read_address !== '0) begin fails++; $display("FAIL reset_mem_addr got %h exp 00", mem_read_address); end
    tests++; if (cready !== '0) begin fails++; $display("FAIL reset_ready got %b exp 00", cready); end
    tests++; if (cdata[0] !== '0 || cdata[1] !== '0) begin fails++; $display("FAIL reset_data got %h %h exp 0 0", cdata[0], cdata[1]); end
    tests++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin fails++; $display("FAIL reset_counts got %0d %0d exp 0 0", hit_count, miss_count); end
    exp_hit = 0; exp_miss = 0;
    step(1);
  endtask

  task automatic test_single_miss();
    cvalid[0] = 1'b1; caddr[0] = 8'h05;
    step(1);
    tests++; if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h05) begin fails++; $display("FAIL miss_issue got v=%b a=%h exp v=1 a=05", mem_read_valid, mem_read_address); end
    step(2);
    tests++; if (mem_read_valid !== 1'b1 || cready !== '0) begin fails++; $display("FAIL miss_wait got v=%b rdy=%b exp v=1 rdy=00", mem_read_valid, cready); end
    man_ready = 1'b1; man_data = 16'hABCD;
    step(1);
    man_ready = 1'b0; exp_miss++;
    tests++; if (cready !== 2'b01 || cdata[0] !== 16'hABCD) begin fails++; $display("FAIL miss_resp got rdy=%b d=%h exp rdy=01 d=abcd", cready, cdata[0]); end
    tests++; if (mem_read_valid !== 1'b0) begin fails++; $display("FAIL miss_drop got %b exp 0", mem_read_valid); end
    tests++; if (miss_count !== 16'(exp_miss) || hit_count !== 16'(exp_hit)) begin fails++; $display("FAIL miss_counts got h=%0d m=%0d exp h=%0d m=%0d", hit_count, miss_count, exp_hit, exp_miss); end
    cvalid[0] = 1'b0;
    step(1);
    tests++; if (cready !== '0) begin fails++; $display("FAIL miss_pulse_width got %b exp 00", cready); end
    step(2);
  endtask

  task automatic test_coalesce();
    cvalid = 2'b11; caddr[0] = 8'h10; caddr[1] = 8'h10;
    step(1);
    tests++; if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h10) begin fails++; $display("FAIL coal_issue got v=%b a=%h exp v=1 a=10", mem_read_valid, mem_read_address); end
    man_ready = 1'b1; man_data = 16'h1234;
    step(1);
    man_ready = 1'b0; exp_miss++;
    tests++; if (cready !== 2'b11) begin fails++; $display("FAIL coal_ready got %b exp 11", cready); end
    tests++; if (cdata[0] !== 16'h1234 || cdata[1] !== 16'h1234) begin fails++; $display("FAIL coal_data got %h %h exp 1234 1234", cdata[0], cdata[1]); end
    tests++; if (miss_count !== 16'(exp_miss)) begin fails++; $display("FAIL coal_miss got %0d exp %0d", miss_count, exp_miss); end
    cvalid = '0;
    step(3);
    tests++; if (mem_read_valid !== 1'b0) begin fails++; $display("FAIL coal_single_txn got %b exp 0", mem_read_valid); end
  endtask

  task automatic test_buffer_hit();
    cvalid[1] = 1'b1; caddr[1] = 8'h10;
    step(1);
    exp_hit++;
    tests++; if (cready !== 2'b10 || cdata[1] !== 16'h1234) begin fails++; $display("FAIL hit_resp got rdy=%b d=%h exp rdy=10 d=1234", cready, cdata[1]); end
    tests++; if (mem_read_valid !== 1'b0) begin fails++; $display("FAIL hit_no_mem got %b exp 0", mem_read_valid); end
    tests++; if (hit_count !== 16'(exp_hit) || miss_count !== 16'(exp_miss)) begin fails++; $display("FAIL hit_counts got h=%0d m=%0d exp h=%0d m=%0d", hit_count, miss_count, exp_hit, exp_miss); end
    tests++; if (cdata[0] !== 16'h1234) begin fails++; $display("FAIL hit_hold_other got %h exp 1234", cdata[0]); end
    cvalid = '0;
    step(3);
  endtask

  task automatic test_flush_hit();
    cvalid[0] = 1'b1; caddr[0] = 8'h10; flush = 1'b1;
    step(1);
    flush = 1'b0;
    tests++; if (mem_read_valid !== 1'b1 || hit_count !== 16'(exp_hit)) begin fails++; $display("FAIL flush_beats_hit got v=%b h=%0d exp v=1 h=%0d", mem_read_valid, hit_count, exp_hit); end
    man_ready = 1'b1; man_data = 16'h4321;
    step(1);
    man_ready = 1'b0; exp_miss++;
    tests++; if (cready !== 2'b01 || cdata[0] !== 16'h4321 || miss_count !== 16'(exp_miss)) begin fails++; $display("FAIL flush_hit_resp got rdy=%b d=%h m=%0d exp rdy=01 d=4321 m=%0d", cready, cdata[0], miss_count, exp_miss); end
    cvalid = '0;
    step(3);
  endtask

  task automatic test_boundary_addr();
    logic [AW-1:0] a [4];
    logic [DW-1:0] d [4];
    logic          is_hit [4];
    a = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    d = '{16'h0F0F, 16'hF0F0, 16'hF0F0, 16'h0A0A};
    is_hit = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      cvalid[0] = 1'b1; caddr[0] = a[k];
      step(1);
      if (!is_hit[k]) begin
        tests++; if (mem_read_valid !== 1'b1 || mem_read_address !== a[k]) begin fails++; $display("FAIL bound_miss[%0d] got v=%b a=%h exp v=1 a=%h", k, mem_read_valid, mem_read_address, a[k]); end
        man_ready = 1'b1; man_data = d[k];
        step(1);
        man_ready = 1'b0; exp_miss++;
      end else begin
        tests++; if (mem_read_valid !== 1'b0) begin fails++; $display("FAIL bound_hit[%0d] got v=%b exp 0", k, mem_read_valid); end
        exp_hit++;
      end
      tests++; if (cready !== 2'b01 || cdata[0] !== d[k]) begin fails++; $display("FAIL bound_resp[%0d] got rdy=%b d=%h exp rdy=01 d=%h", k, cready, cdata[0], d[k]); end
      tests++; if (hit_count !== 16'(exp_hit) || miss_count !== 16'(exp_miss)) begin fails++; $display("FAIL bound_counts[%0d] got h=%0d m=%0d exp h=%0d m=%0d", k, hit_count, miss_count, exp_hit, exp_miss); end
      cvalid = '0;
      step(3);
    end
  endtask

  task automatic test_flush_issue();
    logic [DW-1:0] d1, d2;
    d1 = 16'($urandom); d2 = ~d1;
    cvalid[0] = 1'b1; caddr[0] = 8'h30;
    step(1);
    man_ready = 1'b1; man_data = d1; flush = 1'b1;
    step(1);
    man_ready = 1'b0; flush = 1'b0; exp_miss++;
    tests++; if (cready !== 2'b01 || cdata[0] !== d1) begin fails++; $display("FAIL flush_issue_resp got rdy=%b d=%h exp rdy=01 d=%h", cready, cdata[0], d1); end
    cvalid = '0;
    step(3);
    cvalid[0] = 1'b1;
    step(1);
    tests++; if (mem_read_valid !== 1'b1) begin fails++; $display("FAIL flush_issue_refetch got %b exp 1", mem_read_valid); end
    man_ready = 1'b1; man_data = d2;
    step(1);
    man_ready = 1'b0; exp_miss++;
    tests++; if (cdata[0] !== d2 || miss_count !== 16'(exp_miss) || hit_count !== 16'(exp_hit)) begin fails++; $display("FAIL flush_issue_counts got d=%h h=%0d m=%0d exp d=%h h=%0d m=%0d", cdata[0], hit_count, miss_count, d2, exp_hit, exp_miss); end
    cvalid = '0;
    step(3);
  endtask

  task automatic test_reset_mid_issue();
    cvalid[1] = 1'b1; caddr[1] = 8'h40;
    step(2);
    reset = 1'b1; man_ready = 1'b1; man_data = 16'hBEEF;
    step(1);
    man_ready = 1'b0;
    tests++; if (mem_read_valid !== 1'b0 || cready !== '0) begin fails++; $display("FAIL rst_mid_drop got v=%b rdy=%b exp v=0 rdy=00", mem_read_valid, cready); end
    tests++; if (hit_count !== 16'd0 || miss_count !== 16'd0 || cdata[0] !== '0) begin fails++; $display("FAIL rst_mid_clear got h=%0d m=%0d d0=%h exp 0 0 0", hit_count, miss_count, cdata[0]); end
    step(1);
    reset = 1'b0; exp_hit = 0; exp_miss = 0;
    step(1);
    tests++; if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h40) begin fails++; $display("FAIL rst_mid_reissue got v=%b a=%h exp v=1 a=40", mem_read_valid, mem_read_address); end
    man_ready = 1'b1; man_data = 16'h5A5A;
    step(1);
    man_ready = 1'b0; exp_miss++;
    tests++; if (cready !== 2'b10 || cdata[1] !== 16'h5A5A || miss_count !== 16'(exp_miss)) begin fails++; $display("FAIL rst_mid_resp got rdy=%b d=%h m=%0d exp rdy=10 d=5a5a m=%0d", cready, cdata[1], miss_count, exp_miss); end
    cvalid = '0;
    step(3);
  endtask

  task automatic test_round_robin();
    int order[$];
    int cool[N];
    reset = 1'b1; cvalid = '0; flush = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    mem_auto = 1'b1; mem_rand = 1'b0; mem_lat = 0;
    caddr[0] = 8'h20; caddr[1] = 8'h21; cvalid = 2'b11; flush = 1'b1;
    cool[0] = 0; cool[1] = 0;
    for (int c = 0; c < 300; c++) begin
      step(1);
      flush = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (cready[i]) begin
          order.push_back(i);
          tests++; if (cdata[i] !== mem_tbl[caddr[i]]) begin fails++; $display("FAIL rr_data[%0d] got %h exp %h", i, cdata[i], mem_tbl[caddr[i]]); end
          cvalid[i] = 1'b0; cool[i] = 3;
        end else if (!cvalid[i] && order.size() < 4) begin
          if (cool[i] > 0) cool[i]--;
          else begin cvalid[i] = 1'b1; flush = 1'b1; end
        end
      end
      if (order.size() >= 4 && cvalid == '0) break;
    end
    tests++; if (cvalid !== '0) begin fails++; $display("FAIL rr_timeout pending=%b exp 00", cvalid); end
    tests++;
    if (order.size() < 4) begin fails++; $display("FAIL rr_grants got %0d exp >=4", order.size()); end
    else begin
      for (int k = 0; k < 4; k++)
        if (order[k] != k % 2) begin fails++; $display("FAIL rr_order[%0d] got %0d exp %0d", k, order[k], k % 2); end
    end
    step(3);
    tests++; if (miss_count !== 16'(order.size()) || hit_count !== 16'd0) begin fails++; $display("FAIL rr_counts got h=%0d m=%0d exp h=0 m=%0d", hit_count, miss_count, order.size()); end
  endtask

  task automatic test_random();
    logic [AW-1:0] aset [4];
    int cool[N], waited[N];
    int n_issue, n_serve, max_wait;
    logic prev_mv, found, gen;
    logic [AW-1:0] prev_ma;
    aset = '{8'h00, 8'hFF, 8'h55, 8'h56};
    reset = 1'b1; cvalid = '0; flush = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    mem_rand = 1'b1;
    n_issue = 0; n_serve = 0; max_wait = 0; prev_mv = 1'b0; prev_ma = '0;
    for (int i = 0; i < N; i++) begin cool[i] = 0; waited[i] = 0; end
    for (int c = 0; c < 2500; c++) begin
      step(1);
      gen = (c < 1500);
      if (mem_read_valid && !prev_mv) begin
        n_issue++;
        found = 1'b0;
        for (int i = 0; i < N; i++) if (cvalid[i] && caddr[i] == mem_read_address) found = 1'b1;
        tests++; if (!found) begin fails++; $display("FAIL rand_issue_addr got %h not requested by any fetcher", mem_read_address); end
      end
      if (mem_read_valid && prev_mv) begin
        tests++; if (mem_read_address !== prev_ma) begin fails++; $display("FAIL rand_addr_stable got %h exp %h", mem_read_address, prev_ma); end
      end
      prev_mv = mem_read_valid; prev_ma = mem_read_address;
      if (cready != '0) n_serve++;
      flush = gen && ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if (cready[i]) begin
          tests++; if (!cvalid[i] || cdata[i] !== mem_tbl[caddr[i]]) begin fails++; $display("FAIL rand_resp[%0d] got v=%b d=%h exp v=1 d=%h", i, cvalid[i], cdata[i], mem_tbl[caddr[i]]); end
          if (waited[i] > max_wait) max_wait = waited[i];
          cvalid[i] = 1'b0; cool[i] = $urandom_range(2, 4); waited[i] = 0;
        end else if (cvalid[i]) waited[i]++;
        else if (cool[i] > 0) cool[i]--;
        else if (gen && $urandom_range(0, 2) == 0) begin
          cvalid[i] = 1'b1; caddr[i] = aset[$urandom_range(0, 3)];
        end
      end
      if (!gen && cvalid == '0) break;
    end
    tests++; if (cvalid !== '0) begin fails++; $display("FAIL rand_drain pending=%b exp 00", cvalid); end
    tests++; if (max_wait >= 100) begin fails++; $display("FAIL rand_starve max_wait=%0d exp <100", max_wait); end
    step(4);
    tests++; if (miss_count !== 16'(n_issue)) begin fails++; $display("FAIL rand_miss got %0d exp %0d", miss_count, n_issue); end
    tests++; if (hit_count !== 16'(n_serve - n_issue)) begin fails++; $display("FAIL rand_hit got %0d exp %0d", hit_count, n_serve - n_issue); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_tbl[i] = 16'($urandom);
    caddr[0] = '0; caddr[1] = '0;
    test_reset();
    test_single_miss();
    test_coalesce();
    test_buffer_hit();
    test_flush_hit();
    test_boundary_addr();
    test_flush_issue();
    test_reset_mid_issue();
    test_round_robin();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
